icap_multiboot_seq: RTL

//  Parametrised Artix-7 warm-reboot sequencer. Takes a reboot request plus a runtime flash-slot select.

---
 rtl/icap_multiboot_seq_if.sv | 23 ++
 rtl/icap_multiboot_seq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/icap_multiboot_seq_if.sv
// Request/slot in, status and ICAP word stream out, between reboot control and the ICAPE2 wrapper.
interface icap_multiboot_seq_if #(
    parameter int unsigned SLOT_BITS = 2
);
    logic                 req;
    logic [SLOT_BITS-1:0] slot;
    logic                 busy;
    logic                 done;
    logic                 icap_clk;
    logic                 icap_ce;
    logic                 icap_we;
    logic [31:0]          icap_data;

    modport master (
        output req, slot,
        input  busy, done, icap_clk, icap_ce, icap_we, icap_data
    );

    modport slave (
        input  req, slot,
        output busy, done, icap_clk, icap_ce, icap_we, icap_data
    );
endinterface

// File: rtl/icap_multiboot_seq.sv
// Artix-7 warm-reboot sequencer: streams the IPROG word sequence for a selected flash slot
// to the ICAPE2 wrapper at a divided rate and generates the wrapper's ICAP clock.
module icap_multiboot_seq #(
    parameter int unsigned CLKDIV    = 8,
    parameter int unsigned SLOT_BITS = 2,
    parameter logic [31:0] SLOT_SIZE = 32'h0040_0000,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          ADDR32    = 1'b0,
    parameter int unsigned NOP_TAIL  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    icap_multiboot_seq_if.slave io_bus
);
    // state   | meaning
    // S_IDLE  | waiting for req
    // S_ARMED | slot address latched, waiting for the first word boundary
    // S_SEND  | presenting word r_idx
    // S_DONE  | all words sent, idle outputs, holds until reset
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SEND, S_DONE} state_t;

    localparam int unsigned DW       = $clog2(CLKDIV);
    localparam logic [8:0]  LAST_IDX = 9'(6 + NOP_TAIL);

    state_t               r_state, w_state_nxt;
    logic [DW-1:0]        r_dcnt, w_dcnt_nxt;
    logic                 w_tick;
    logic [8:0]           r_idx, w_idx_nxt;
    logic [31:0]          r_addr, w_addr_nxt;
    logic [SLOT_BITS-1:0] w_slot;
    logic [31:0]          w_byte_addr;
    logic [31:0]          w_wbstar;
    logic                 r_icap_clk;
    logic                 r_ce, r_we, w_ce, w_we;
    logic [31:0]          r_data, w_data;

    assign w_slot      = io_bus.slot;
    assign w_byte_addr = BASE_ADDR + 32'(w_slot) * SLOT_SIZE;
    assign w_wbstar    = ADDR32 ? {8'h00, r_addr[31:8]} : {8'h00, r_addr[23:0]};

    assign w_tick     = (r_dcnt == DW'(CLKDIV - 1));
    assign w_dcnt_nxt = w_tick ? '0 : r_dcnt + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_dcnt     <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_icap_clk <= 1'b0;
            r_ce       <= 1'b0;
            r_we       <= 1'b0;
            r_data     <= 32'hFFFF_FFFF;
        end else begin
            r_state    <= w_state_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_idx      <= w_idx_nxt;
            r_addr     <= w_addr_nxt;
            // registered so icap_clk tracks the count it is derived from without a lag
            r_icap_clk <= (w_dcnt_nxt >= DW'(CLKDIV / 2));
            r_ce       <= w_ce;
            r_we       <= w_we;
            r_data     <= w_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_addr_nxt  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (io_bus.req) begin
                    w_state_nxt = S_ARMED;
                    w_addr_nxt  = w_byte_addr;
                end
            end
            S_ARMED: begin
                if (w_tick) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = '0;
                end
            end
            S_SEND: begin
                if (w_tick) begin
                    if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
                    else                   w_idx_nxt   = r_idx + 9'd1;
                end
            end
            default: w_state_nxt = S_DONE;
        endcase
    end

    // Word for the coming period, loaded into the output registers on the same edge as the state.
    always_comb begin
        w_ce   = 1'b0;
        w_we   = 1'b0;
        w_data = 32'hFFFF_FFFF;
        if (w_state_nxt == S_SEND && w_idx_nxt != 9'd0) begin
            w_ce = 1'b1;
            w_we = 1'b1;
            case (w_idx_nxt)
                9'd1:    w_data = 32'hAA99_5566;
                9'd2:    w_data = 32'h2000_0000;
                9'd3:    w_data = 32'h3002_0001;
                9'd4:    w_data = w_wbstar;
                9'd5:    w_data = 32'h3000_8001;
                9'd6:    w_data = 32'h0000_000F;
                default: w_data = 32'h2000_0000;
            endcase
        end
    end

    assign io_bus.busy      = (r_state != S_IDLE);
    assign io_bus.done      = (r_state == S_DONE);
    assign io_bus.icap_clk  = r_icap_clk;
    assign io_bus.icap_ce   = r_ce;
    assign io_bus.icap_we   = r_we;
    assign io_bus.icap_data = r_data;
endmodule
